// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction queue between the fetch stage and decode. It buffers
//   (PC, instruction) pairs from fetch and the instruction memory, and presents
//   the oldest pair to decode in first-word-fall-through order. Fetch stalls
//   while full_F is high. A taken branch (flush) discards every queued entry.
//
// Parameters
//   N      PC width in bits
//   DEPTH  number of entries (power of two, >= 2)
//
// Ports
//   clk      rising-edge clock
//   reset    synchronous, active-high; empties the queue
//   push_F   fetch offers pc_F/instr_F this cycle
//   pc_F     PC of the offered instruction
//   instr_F  instruction word read at pc_F
//   full_F   queue holds DEPTH entries; fetch must hold its PC
//   pop_D    decode consumes the head entry this cycle
//   valid_D  head entry present
//   pc_D     PC of the head entry (zero when empty)
//   instr_D  instruction of the head entry (zero when empty)
//   flush    taken branch; discard all entries, including a same-cycle push
//   count    current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int N     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_F,
    input  logic [N-1:0]             pc_F,
    input  logic [31:0]              instr_F,
    output logic                     full_F,
    input  logic                     pop_D,
    output logic                     valid_D,
    output logic [N-1:0]             pc_D,
    output logic [31:0]              instr_D,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    // Storage is deliberately not reset; the output mux hides stale contents.
    logic [N-1:0]  pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   occ;

    logic          push_acc;
    logic          pop_acc;

    assign full_F  = (occ == (AW+1)'(DEPTH));
    assign valid_D = (occ != '0);
    assign count   = occ;

    // Flush outranks both sides: the same-cycle push is wrong-path and the pop
    // is moot because the whole queue is discarded anyway.
    assign push_acc = push_F & ~full_F & ~flush;
    assign pop_acc  = pop_D & valid_D & ~flush;

    // Control state: pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            occ <= occ + (AW+1)'(push_acc) - (AW+1)'(pop_acc);
        end
    end

    // Data storage: written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            pc_mem[wr_ptr]    <= pc_F;
            instr_mem[wr_ptr] <= instr_F;
        end
    end

    // Force zeros when empty so no uninitialised entry can leak out as X.
    assign pc_D    = valid_D ? pc_mem[rd_ptr]    : '0;
    assign instr_D = valid_D ? instr_mem[rd_ptr] : '0;

endmodule
